// File: rtl/e203_icb_dma_mc.sv
// e203_icb_dma_mc: multi-channel ICB DMA moving one word per grant, round-robin over busy channels.
// Define E203_DMA_IRQ_EN to implement CTRL.IE and the registered irq output.
`timescale 1ns/1ps
module e203_icb_dma_mc #(
    parameter int NCH  = 4,
    parameter int AW   = 32,
    parameter int LENW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_icb_cmd_valid,
    output logic          s_icb_cmd_ready,
    input  logic [AW-1:0] s_icb_cmd_addr,
    input  logic          s_icb_cmd_read,
    input  logic [31:0]   s_icb_cmd_wdata,
    input  logic [3:0]    s_icb_cmd_wmask,
    output logic          s_icb_rsp_valid,
    input  logic          s_icb_rsp_ready,
    output logic          s_icb_rsp_err,
    output logic [31:0]   s_icb_rsp_rdata,
    output logic          m_icb_cmd_valid,
    input  logic          m_icb_cmd_ready,
    output logic [AW-1:0] m_icb_cmd_addr,
    output logic          m_icb_cmd_read,
    output logic [31:0]   m_icb_cmd_wdata,
    output logic [3:0]    m_icb_cmd_wmask,
    input  logic          m_icb_rsp_valid,
    output logic          m_icb_rsp_ready,
    input  logic          m_icb_rsp_err,
    input  logic [31:0]   m_icb_rsp_rdata,
    output logic          irq
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    typedef enum logic [2:0] {IDLE, ARB, RD_CMD, RD_RSP, WR_CMD, WR_RSP} state_t;
    state_t state;
    logic [AW-1:0] src [NCH];
    logic [AW-1:0] dst [NCH];
    logic [LENW-1:0] len [NCH];
    logic [NCH-1:0] busy, done, err, ie;
    logic [CW-1:0] last_grant, cur, gnt, s_idx;
    logic gnt_vld, rsp_pending, s_fire, s_bad, s_wr, unused;
    logic [3:0] s_ch;
    logic [1:0] s_reg;
    logic [AW-1:0] s_addr_w;
    logic [31:0] rd_mux;

    assign s_ch = s_icb_cmd_addr[7:4];
    assign s_reg = s_icb_cmd_addr[3:2];
    assign s_idx = s_ch[CW-1:0];
    assign s_bad = int'(s_ch) >= NCH;
    assign s_fire = s_icb_cmd_valid & s_icb_cmd_ready;
    assign s_wr = s_fire & ~s_icb_cmd_read & ~s_bad;
    assign s_addr_w = AW'({s_icb_cmd_wdata[31:2], 2'b00});
    assign s_icb_cmd_ready = ~rsp_pending;
    assign s_icb_rsp_valid = rsp_pending;
    assign unused = ^{s_icb_cmd_wmask, s_icb_cmd_addr[AW-1:8], s_icb_cmd_addr[1:0]};
    assign rd_mux = s_bad ? 32'h0 : s_reg == 2'd0 ? 32'(src[s_idx]) : s_reg == 2'd1 ? 32'(dst[s_idx]) :
                    s_reg == 2'd2 ? 32'(len[s_idx]) : {28'h0, ie[s_idx], err[s_idx], done[s_idx], busy[s_idx]};

    // Walk downward so the nearest busy channel after last_grant is the one that sticks.
    always_comb begin
        gnt = '0;
        gnt_vld = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            if (busy[CW'((int'(last_grant) + i) % NCH)]) begin
                gnt = CW'((int'(last_grant) + i) % NCH);
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_pending <= 1'b0;
            s_icb_rsp_err <= 1'b0;
            s_icb_rsp_rdata <= '0;
        end else if (s_fire) begin
            rsp_pending <= 1'b1;
            s_icb_rsp_err <= s_bad;
            s_icb_rsp_rdata <= s_icb_cmd_read ? rd_mux : 32'h0;
        end else if (s_icb_rsp_ready) begin
            rsp_pending <= 1'b0;
        end
    end

    // Register writes come first so the engine's DONE/ERR sets override a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= CW'(NCH - 1);
            cur <= '0;
            busy <= '0;
            done <= '0;
            err <= '0;
            m_icb_cmd_valid <= 1'b0;
            m_icb_cmd_read <= 1'b0;
            m_icb_cmd_addr <= '0;
            m_icb_cmd_wdata <= '0;
            m_icb_cmd_wmask <= '0;
            m_icb_rsp_ready <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                src[i] <= '0;
                dst[i] <= '0;
                len[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s_wr && s_idx == CW'(i)) begin
                    if (s_reg == 2'd0 && !busy[i]) src[i] <= s_addr_w;
                    if (s_reg == 2'd1 && !busy[i]) dst[i] <= s_addr_w;
                    if (s_reg == 2'd2 && !busy[i]) len[i] <= s_icb_cmd_wdata[LENW-1:0];
                    if (s_reg == 2'd3) begin
                        if (s_icb_cmd_wdata[1]) done[i] <= 1'b0;
                        if (s_icb_cmd_wdata[2]) err[i] <= 1'b0;
                        if (s_icb_cmd_wdata[0] && !busy[i]) begin
                            if (len[i] == '0) done[i] <= 1'b1;
                            else busy[i] <= 1'b1;
                        end
                    end
                end
            end
            case (state)
                IDLE: if (|busy) state <= ARB;
                ARB: begin
                    if (gnt_vld) begin
                        cur <= gnt;
                        last_grant <= gnt;
                        m_icb_cmd_valid <= 1'b1;
                        m_icb_cmd_read <= 1'b1;
                        m_icb_cmd_addr <= src[gnt];
                        m_icb_cmd_wmask <= 4'h0;
                        state <= RD_CMD;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_CMD: if (m_icb_cmd_ready) begin
                    m_icb_cmd_valid <= 1'b0;
                    m_icb_rsp_ready <= 1'b1;
                    state <= RD_RSP;
                end
                RD_RSP: if (m_icb_rsp_valid) begin
                    m_icb_rsp_ready <= 1'b0;
                    if (m_icb_rsp_err) begin
                        err[cur] <= 1'b1;
                        busy[cur] <= 1'b0;
                        state <= ARB;
                    end else begin
                        m_icb_cmd_valid <= 1'b1;
                        m_icb_cmd_read <= 1'b0;
                        m_icb_cmd_addr <= dst[cur];
                        m_icb_cmd_wdata <= m_icb_rsp_rdata;
                        m_icb_cmd_wmask <= 4'hF;
                        state <= WR_CMD;
                    end
                end
                WR_CMD: if (m_icb_cmd_ready) begin
                    m_icb_cmd_valid <= 1'b0;
                    m_icb_rsp_ready <= 1'b1;
                    state <= WR_RSP;
                end
                WR_RSP: if (m_icb_rsp_valid) begin
                    m_icb_rsp_ready <= 1'b0;
                    state <= ARB;
                    if (m_icb_rsp_err) begin
                        err[cur] <= 1'b1;
                        busy[cur] <= 1'b0;
                    end else begin
                        src[cur] <= src[cur] + AW'(4);
                        dst[cur] <= dst[cur] + AW'(4);
                        len[cur] <= len[cur] - LENW'(1);
                        if (len[cur] == LENW'(1)) begin
                            busy[cur] <= 1'b0;
                            done[cur] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef E203_DMA_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie <= '0;
            irq <= 1'b0;
        end else begin
            if (s_wr && s_reg == 2'd3) ie[s_idx] <= s_icb_cmd_wdata[3];
            irq <= |((done | err) & ie);
        end
    end
`else
    assign ie = '0;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_e203_icb_dma_mc.sv
// tb_e203_icb_dma_mc: randomized bench with a memory model and spec-level expectations for the DMA.
`timescale 1ns/1ps
module tb_e203_icb_dma_mc;
    logic clk = 0, rst_n = 0;
    logic s_icb_cmd_valid = 0, s_icb_cmd_read = 0, s_icb_rsp_ready = 1;
    logic [31:0] s_icb_cmd_addr = 0, s_icb_cmd_wdata = 0;
    logic [3:0] s_icb_cmd_wmask = 4'hF;
    logic s_icb_cmd_ready, s_icb_rsp_valid, s_icb_rsp_err;
    logic [31:0] s_icb_rsp_rdata;
    logic m_icb_cmd_valid, m_icb_cmd_read, m_icb_rsp_ready, irq;
    logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
    logic [3:0] m_icb_cmd_wmask;
    logic m_icb_cmd_ready = 1, m_icb_rsp_valid = 0, m_icb_rsp_err = 0;
    logic [31:0] m_icb_rsp_rdata = 0;
    int tests = 0, fails = 0, cyc = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] log_addr [$];
    logic log_rd [$];
    int log_cyc [$];
    logic stall_wr = 0, rand_ready = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    e203_icb_dma_mc dut (
        .clk(clk), .rst_n(rst_n),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
        .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    // Memory slave: decisions made at negedge hold through the next posedge; response one cycle after accept.
    initial begin
        logic cmd_fire, rsp_fire, nxt_err;
        logic [31:0] nxt_rdata;
        cmd_fire = 0; rsp_fire = 0; nxt_err = 0; nxt_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_icb_rsp_valid = 0; m_icb_cmd_ready = 1; cmd_fire = 0; rsp_fire = 0;
                continue;
            end
            if (rsp_fire) m_icb_rsp_valid = 0;
            if (cmd_fire) begin
                m_icb_rsp_valid = 1; m_icb_rsp_rdata = nxt_rdata; m_icb_rsp_err = nxt_err;
            end
            m_icb_cmd_ready = (stall_wr && m_icb_cmd_valid && !m_icb_cmd_read) ? 1'b0 :
                              rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_fire = m_icb_cmd_valid && m_icb_cmd_ready;
            if (cmd_fire) begin
                log_addr.push_back(m_icb_cmd_addr); log_rd.push_back(m_icb_cmd_read); log_cyc.push_back(cyc);
                nxt_err = m_icb_cmd_read && m_icb_cmd_addr == err_addr;
                nxt_rdata = m_icb_cmd_read ? mem_rd(m_icb_cmd_addr) : 32'h0;
                if (!m_icb_cmd_read) mem[m_icb_cmd_addr] = m_icb_cmd_wdata;
            end
            rsp_fire = m_icb_rsp_valid && m_icb_rsp_ready;
        end
    end

    task automatic sl_xfer(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                           output logic [31:0] rdat, output logic e);
        int n;
        n = 0;
        @(negedge clk);
        s_icb_cmd_valid = 1; s_icb_cmd_addr = a; s_icb_cmd_read = rd; s_icb_cmd_wdata = wd;
        while (!s_icb_cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        s_icb_cmd_valid = 0;
        tests++;
        if (s_icb_rsp_valid !== 1'b1) begin
            fails++; $display("FAIL slave_rsp addr=%h rsp_valid=%b expected 1", a, s_icb_rsp_valid);
        end
        rdat = s_icb_rsp_rdata; e = s_icb_rsp_err;
    endtask

    task automatic sl_wr(input int ch, input int r, input logic [31:0] d);
        logic [31:0] x; logic e;
        sl_xfer(32'(ch * 16 + r * 4), 1'b0, d, x, e);
    endtask

    task automatic sl_rd(input int ch, input int r, output logic [31:0] d);
        logic e;
        sl_xfer(32'(ch * 16 + r * 4), 1'b1, 32'h0, d, e);
    endtask

    task automatic wait_idle();
        logic [31:0] c; int n; bit any;
        n = 0;
        do begin
            any = 0;
            for (int i = 0; i < 4; i++) begin sl_rd(i, 3, c); if (c[0]) any = 1; end
            n++;
        end while (any && n < 300);
        tests++;
        if (any) begin fails++; $display("FAIL wait_idle channels still busy after %0d polls, expected idle", n); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        tests++;
        if ({s_icb_cmd_ready, s_icb_rsp_valid, m_icb_cmd_valid, irq} !== 4'b1000) begin
            fails++; $display("FAIL reset_outputs got %b expected 1000",
                              {s_icb_cmd_ready, s_icb_rsp_valid, m_icb_cmd_valid, irq});
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                sl_rd(c, r, d);
                tests++;
                if (d !== 32'h0) begin fails++; $display("FAIL reset_reg ch%0d r%0d got %h expected 0", c, r, d); end
            end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        sl_wr(1, 0, 32'h0000_0303); sl_rd(1, 0, d);
        tests++;
        if (d !== 32'h300) begin fails++; $display("FAIL src_align got %h expected 300", d); end
        sl_wr(1, 2, 32'h0001_2345); sl_rd(1, 2, d);
        tests++;
        if (d !== 32'h2345) begin fails++; $display("FAIL len_width got %h expected 2345", d); end
        sl_wr(1, 2, 0);
    endtask

    task automatic test_single();
        logic [31:0] d; int b;
        b = log_addr.size();
        sl_wr(0, 0, 32'h100); sl_wr(0, 1, 32'h200); sl_wr(0, 2, 4); sl_wr(0, 3, 1);
        wait_idle();
        tests++;
        if (log_addr.size() - b != 8) begin
            fails++; $display("FAIL single_beats got %0d expected 8", log_addr.size() - b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (log_addr[b+2*k] !== 32'(32'h100 + 4 * k) || log_rd[b+2*k] !== 1'b1 ||
                    log_addr[b+2*k+1] !== 32'(32'h200 + 4 * k) || log_rd[b+2*k+1] !== 1'b0) begin
                    fails++; $display("FAIL single_order word%0d got rd %h wr %h expected %h %h", k,
                                      log_addr[b+2*k], log_addr[b+2*k+1], 32'h100 + 4 * k, 32'h200 + 4 * k);
                end
                tests++;
                if (log_cyc[b+2*k] - log_cyc[b] != 5 * k || log_cyc[b+2*k+1] - log_cyc[b+2*k] != 2) begin
                    fails++; $display("FAIL single_timing word%0d got %0d/%0d expected %0d/2", k,
                                      log_cyc[b+2*k] - log_cyc[b], log_cyc[b+2*k+1] - log_cyc[b+2*k], 5 * k);
                end
                tests++;
                if (mem_rd(32'(32'h200 + 4 * k)) !== pat(32'(32'h100 + 4 * k))) begin
                    fails++; $display("FAIL single_data word%0d got %h expected %h", k,
                                      mem_rd(32'(32'h200 + 4 * k)), pat(32'(32'h100 + 4 * k)));
                end
            end
        end
        sl_rd(0, 3, d); tests++;
        if (d !== 32'h2) begin fails++; $display("FAIL single_ctrl got %h expected 2", d); end
        sl_rd(0, 0, d); tests++;
        if (d !== 32'h110) begin fails++; $display("FAIL single_src got %h expected 110", d); end
        sl_rd(0, 2, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL single_len got %h expected 0", d); end
        sl_wr(0, 3, 2); sl_rd(0, 3, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL done_w1c got %h expected 0", d); end
    endtask

    task automatic test_interleave();
        logic [31:0] w [$]; logic [31:0] exp_w [4]; int b;
        exp_w = '{32'h2000, 32'h4000, 32'h2004, 32'h4004};
        b = log_addr.size();
        sl_wr(0, 0, 32'h1000); sl_wr(0, 1, 32'h2000); sl_wr(0, 2, 2);
        sl_wr(2, 0, 32'h3000); sl_wr(2, 1, 32'h4000); sl_wr(2, 2, 2);
        sl_wr(0, 3, 1); sl_wr(2, 3, 1);
        wait_idle();
        for (int i = b; i < log_addr.size(); i++) if (!log_rd[i]) w.push_back(log_addr[i]);
        tests++;
        if (w.size() != 4) begin
            fails++; $display("FAIL interleave_count got %0d expected 4", w.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (w[k] !== exp_w[k]) begin
                    fails++; $display("FAIL interleave_order beat%0d got %h expected %h", k, w[k], exp_w[k]);
                end
            end
        end
        sl_wr(0, 3, 2); sl_wr(2, 3, 2);
    endtask

    task automatic test_error();
        logic [31:0] d; int b; bit bad_wr;
        b = log_addr.size();
        err_addr = 32'h504;
        sl_wr(1, 0, 32'h500); sl_wr(1, 1, 32'h600); sl_wr(1, 2, 3); sl_wr(1, 3, 1);
        wait_idle();
        err_addr = 32'hFFFF_FFFF;
        bad_wr = 0;
        for (int i = b; i < log_addr.size(); i++) if (!log_rd[i] && log_addr[i] == 32'h604) bad_wr = 1;
        tests++;
        if (bad_wr) begin fails++; $display("FAIL err_nowrite got write to 604 expected none"); end
        sl_rd(1, 3, d); tests++;
        if (d !== 32'h4) begin fails++; $display("FAIL err_ctrl got %h expected 4", d); end
        sl_rd(1, 0, d); tests++;
        if (d !== 32'h504) begin fails++; $display("FAIL err_src got %h expected 504", d); end
        sl_rd(1, 1, d); tests++;
        if (d !== 32'h604) begin fails++; $display("FAIL err_dst got %h expected 604", d); end
        sl_rd(1, 2, d); tests++;
        if (d !== 32'h2) begin fails++; $display("FAIL err_len got %h expected 2", d); end
        sl_wr(1, 3, 4); sl_rd(1, 3, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL err_w1c got %h expected 0", d); end
    endtask

    task automatic test_len0();
        logic [31:0] d; int b; bit seen;
        b = log_addr.size();
        sl_wr(3, 3, 1); sl_rd(3, 3, d); tests++;
        if (d !== 32'h2) begin fails++; $display("FAIL len0_done got %h expected 2", d); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (m_icb_cmd_valid) seen = 1; end
        tests++;
        if (seen || log_addr.size() != b) begin
            fails++; $display("FAIL len0_traffic got valid=%b beats=%0d expected 0 0", seen, log_addr.size() - b);
        end
        sl_wr(3, 3, 2); sl_rd(3, 3, d); tests++;
        if (d !== 32'h0) begin fails++; $display("FAIL len0_w1c got %h expected 0", d); end
    endtask

    task automatic test_bad_chan();
        logic [31:0] d; logic e;
        sl_xfer(32'h80, 1'b1, 32'h0, d, e); tests++;
        if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL bad_read got err=%b rdata=%h expected 1 0", e, d); end
        sl_xfer(32'h40, 1'b0, 32'h5555, d, e); tests++;
        if (e !== 1'b1) begin fails++; $display("FAIL bad_write got err=%b expected 1", e); end
        sl_xfer(32'h0, 1'b1, 32'h0, d, e); tests++;
        if (e !== 1'b0 || d !== 32'h1008) begin
            fails++; $display("FAIL good_read got err=%b rdata=%h expected 0 1008", e, d);
        end
    endtask

    task automatic test_random();
        logic [31:0] src_e [4], dst_e [4], d; int len_e [4]; int b, nw, tot;
        rand_ready = 1;
        b = log_addr.size(); tot = 0;
        for (int i = 0; i < 4; i++) begin
            src_e[i] = 32'(32'h10000 + i * 32'h1000 + $urandom_range(0, 15) * 4);
            dst_e[i] = 32'(32'h20000 + i * 32'h1000 + $urandom_range(0, 15) * 4);
            len_e[i] = $urandom_range(2, 6); tot += len_e[i];
            sl_wr(i, 0, src_e[i]); sl_wr(i, 1, dst_e[i]); sl_wr(i, 2, 32'(len_e[i]));
        end
        for (int i = 0; i < 4; i++) sl_wr(i, 3, 1);
        sl_wr(0, 0, 32'hDEAD_0000); sl_wr(0, 2, 99); sl_wr(0, 3, 1);
        wait_idle();
        nw = 0;
        for (int i = b; i < log_addr.size(); i++) if (!log_rd[i]) nw++;
        tests++;
        if (nw != tot) begin fails++; $display("FAIL rand_writes got %0d expected %0d", nw, tot); end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < len_e[i]; k++) begin
                tests++;
                if (mem_rd(32'(dst_e[i] + 4 * k)) !== pat(32'(src_e[i] + 4 * k))) begin
                    fails++; $display("FAIL rand_data ch%0d word%0d got %h expected %h", i, k,
                                      mem_rd(32'(dst_e[i] + 4 * k)), pat(32'(src_e[i] + 4 * k)));
                end
            end
            sl_rd(i, 0, d); tests++;
            if (d !== 32'(src_e[i] + 4 * len_e[i])) begin
                fails++; $display("FAIL rand_src ch%0d got %h expected %h", i, d, src_e[i] + 4 * len_e[i]);
            end
            sl_rd(i, 1, d); tests++;
            if (d !== 32'(dst_e[i] + 4 * len_e[i])) begin
                fails++; $display("FAIL rand_dst ch%0d got %h expected %h", i, d, dst_e[i] + 4 * len_e[i]);
            end
            sl_rd(i, 3, d); tests++;
            if (d !== 32'h2) begin fails++; $display("FAIL rand_ctrl ch%0d got %h expected 2", i, d); end
            sl_wr(i, 3, 2);
        end
        rand_ready = 0;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        sl_wr(3, 3, 32'h9); @(negedge clk); tests++;
`ifdef E203_DMA_IRQ_EN
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b expected 1", irq); end
        sl_rd(3, 3, d); tests++;
        if (d !== 32'hA) begin fails++; $display("FAIL irq_ctrl got %h expected a", d); end
        sl_wr(3, 3, 32'hA); @(negedge clk); tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b expected 0", irq); end
        sl_wr(3, 3, 32'h0);
`else
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_tied got %b expected 0", irq); end
        sl_rd(3, 3, d); tests++;
        if (d !== 32'h2) begin fails++; $display("FAIL ie_absent got %h expected 2", d); end
        sl_wr(3, 3, 32'h2);
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int n, b;
        stall_wr = 1;
        sl_wr(0, 0, 32'h700); sl_wr(0, 1, 32'h800); sl_wr(0, 2, 4); sl_wr(0, 3, 1);
        n = 0;
        while (!(m_icb_cmd_valid && !m_icb_cmd_read) && n < 100) begin @(negedge clk); n++; end
        tests++;
        if (n >= 100) begin fails++; $display("FAIL reset_mid_reach got timeout expected WR_CMD"); end
        rst_n = 0;
        @(negedge clk); tests++;
        if (m_icb_cmd_valid !== 1'b0 || m_icb_rsp_ready !== 1'b0) begin
            fails++; $display("FAIL reset_mid_valid got %b%b expected 00", m_icb_cmd_valid, m_icb_rsp_ready);
        end
        @(negedge clk); rst_n = 1; stall_wr = 0;
        b = log_addr.size();
        for (int c = 0; c < 4; c++) begin
            sl_rd(c, 3, d); tests++;
            if (d !== 32'h0) begin fails++; $display("FAIL reset_mid_ctrl ch%0d got %h expected 0", c, d); end
        end
        repeat (20) @(negedge clk);
        tests++;
        if (log_addr.size() != b) begin
            fails++; $display("FAIL reset_mid_quiet got %0d beats expected 0", log_addr.size() - b);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_regs();
        test_single();
        test_interleave();
        test_error();
        test_len0();
        test_bad_chan();
        test_random();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
